chip_stream_loader: RTL and testbench
=====================================

// Module: chip_stream_loader
// PURPOSE
//  Host-side transmitter for the accelerator's a/b load interface. On start, streams the input feature tile, then
//  the kernel set, from a host source memory into the chip: a = {sel,addr}, b = data, with valid/ready handshake.
//  Drives int_mem_we per accepted beat and pulses data_ready once everything is loaded.
// PARAMETERS
//  IO_DATA_WIDTH   16      width of a_input, b_input, src_qout
//  INPUT_WORDS     1<<14   feature words; src addr 0..INPUT_WORDS-1 -> chip addr 0..INPUT_WORDS-1, a[15]=0
//  KERNEL_WORDS    1<<9    kernel words; src addr INPUT_WORDS.. -> chip addr 0..KERNEL_WORDS-1, a[15]=1
//  SRC_ADDR_WIDTH  15      $clog2(INPUT_WORDS+KERNEL_WORDS)
// PORTS
//  clk            in   1      single clock, all state on rising edge
//  arst_in        in   1      asynchronous reset, active-high
//  start          in   1      one-cycle request, sampled in IDLE only
//  busy           out  1      high from cycle after start until done
//  done           out  1      one-cycle pulse after last beat accepted
//  src_read_en    out  1      source memory read enable (1-cycle latency, qout held while read_en low)
//  src_read_addr  out  SRC_ADDR_WIDTH  source word address
//  src_qout       in   IO_DATA_WIDTH   source data
//  a_input        out  IO_DATA_WIDTH   {sel, 1'b0, chip addr[13:0]}
//  a_valid        out  1      beat valid
//  a_ready        in   1      chip address side ready
//  b_input        out  IO_DATA_WIDTH   data word (= src_qout while in SEND)
//  b_valid        out  1      equals a_valid
//  b_ready        in   1      chip data side ready
//  int_mem_we     out  1      = a_valid & a_ready & b_ready (combinational, fire cycle)
//  data_ready     out  1      one-cycle pulse, same cycle as done
// BEHAVIOUR
//  Reset: state IDLE, counters 0; busy, done, data_ready, a_valid, b_valid, src_read_en = 0; a_input = 0.
//  FSM: IDLE -start-> PRIME (src_read_en=1, addr=0) -> SEND -last fire-> FINISH -> IDLE.
//  Fire = a_valid & a_ready & b_ready. No fire: valid held, a_input/b_input stable, no read issued.
//  SEND: on fire and not last, issue read of cnt+1 same cycle; valid stays high -> 1 beat/cycle when ready held.
//  Beat order: feature words 0..INPUT_WORDS-1 then kernel 0..KERNEL_WORDS-1; exactly INPUT_WORDS+KERNEL_WORDS fires.
//  Phase switch at cnt==INPUT_WORDS: a[15] goes 1, chip addr restarts at 0; no bubble.
//  Last fire: valid drops next cycle; FINISH pulses done and data_ready for one cycle; busy low in that cycle's next.
//  Latency: start at cycle t -> first a_valid at t+2; last beat fire f -> done at f+1.
//  start while busy: ignored. start in FINISH cycle: ignored (IDLE only).
//  Only one of a_ready/b_ready high: no fire, no int_mem_we.
//  arst_in mid-stream: immediate return to reset state; restart on next start begins from word 0.
//  Counter width SRC_ADDR_WIDTH; compare against total-1, never wraps.
// STRUCTURE
//  Shared package: loader_state_e {IDLE, PRIME, SEND, FINISH}; KERNEL_SEL_BIT = 15; CHIP_ADDR_BITS = 14.
//  Single module; no sub-module. Address/sel mapping as one combinational function in the package.
// TESTING
//  1 reset, no start -> all outputs 0 for 20 cycles.
//  2 INPUT_WORDS=4, KERNEL_WORDS=2, readies held 1, src[i]=i+0x100 -> 6 back-to-back fires,
//    a = 0x0000..0x0003, 0x8000, 0x8001; b = 0x100..0x105; done/data_ready at last fire+1.
//  3 same, b_ready toggles 1/0, a_ready held -> 6 fires only on b_ready cycles, data stable when stalled.
//  4 start pulsed again at beat 2 -> ignored; exactly 6 fires, single done.
//  5 arst_in at beat 3 -> valid 0 same cycle; new start -> stream restarts with a=0x0000, b=0x100.
//  6 a_ready=1, b_ready=0 for 10 cycles -> int_mem_we never high, a_input stays 0x0000.

Source files
------------

// File: rtl/chip_stream_loader_pkg.sv
// Shared definitions for the host-side a/b stream loader: FSM states,
// chip address layout and the beat -> {sel, addr} mapping.
package chip_stream_loader_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        PRIME  = 2'd1,
        SEND   = 2'd2,
        FINISH = 2'd3
    } loader_state_e;

    // a_input layout: bit 15 selects kernel space, bit 14 reserved zero,
    // bits 13:0 carry the word address inside the selected space.
    localparam int KERNEL_SEL_BIT = 15;
    localparam int CHIP_ADDR_BITS = 14;
    localparam int A_WIDTH        = 16;

    // Maps a linear beat index to the chip-side a word. Beats below
    // input_words are feature words; the rest are kernel words whose
    // chip address restarts at zero.
    function automatic logic [A_WIDTH-1:0] map_beat_addr(
        input logic [31:0] beat,
        input logic [31:0] input_words
    );
        logic [A_WIDTH-1:0] a;
        a = '0;
        if (beat < input_words) begin
            a[CHIP_ADDR_BITS-1:0] = CHIP_ADDR_BITS'(beat);
        end else begin
            a[KERNEL_SEL_BIT]     = 1'b1;
            a[CHIP_ADDR_BITS-1:0] = CHIP_ADDR_BITS'(beat - input_words);
        end
        return a;
    endfunction

endpackage

// File: rtl/chip_stream_loader.sv
// Host-side transmitter: on start, reads the feature tile then the kernel
// set out of a 1-cycle-latency source memory and streams them to the chip
// over the a/b valid/ready interface, one beat per cycle when both readies
// are held. Pulses done/data_ready once the final beat has been accepted.
module chip_stream_loader
    import chip_stream_loader_pkg::*;
#(
    parameter int IO_DATA_WIDTH  = 16,
    parameter int INPUT_WORDS    = 1 << 14,
    parameter int KERNEL_WORDS   = 1 << 9,
    parameter int SRC_ADDR_WIDTH = $clog2(INPUT_WORDS + KERNEL_WORDS)
) (
    input  logic                      clk,
    input  logic                      arst_in,
    input  logic                      start,
    output logic                      busy,
    output logic                      done,
    output logic                      src_read_en,
    output logic [SRC_ADDR_WIDTH-1:0] src_read_addr,
    input  logic [IO_DATA_WIDTH-1:0]  src_qout,
    output logic [IO_DATA_WIDTH-1:0]  a_input,
    output logic                      a_valid,
    input  logic                      a_ready,
    output logic [IO_DATA_WIDTH-1:0]  b_input,
    output logic                      b_valid,
    input  logic                      b_ready,
    output logic                      int_mem_we,
    output logic                      data_ready
);

    localparam int TOTAL_WORDS = INPUT_WORDS + KERNEL_WORDS;
    localparam logic [SRC_ADDR_WIDTH-1:0] LAST_BEAT = SRC_ADDR_WIDTH'(TOTAL_WORDS - 1);

    loader_state_e             state_q, state_d;
    logic [SRC_ADDR_WIDTH-1:0] cnt_q, cnt_d;
    logic                      fire;
    logic                      last_beat;

    // A beat is transferred only when both chip sides accept it together.
    assign fire       = a_valid & a_ready & b_ready;
    assign last_beat  = (cnt_q == LAST_BEAT);
    assign int_mem_we = fire;
    assign b_valid    = a_valid;

    // State and beat counter; reset drops any stream in flight at once.
    always_ff @(posedge clk or posedge arst_in) begin
        if (arst_in) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state, counter update and handshake/memory outputs.
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        busy          = 1'b0;
        done          = 1'b0;
        data_ready    = 1'b0;
        a_valid       = 1'b0;
        a_input       = '0;
        b_input       = '0;
        src_read_en   = 1'b0;
        src_read_addr = '0;
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (start) state_d = PRIME;
            end
            PRIME: begin
                // Fetch word 0 so its data is on src_qout when SEND begins.
                busy          = 1'b1;
                src_read_en   = 1'b1;
                src_read_addr = '0;
                state_d       = SEND;
            end
            SEND: begin
                busy    = 1'b1;
                a_valid = 1'b1;
                a_input = IO_DATA_WIDTH'(map_beat_addr(32'(cnt_q), 32'(INPUT_WORDS)));
                b_input = src_qout;
                if (fire) begin
                    if (last_beat) begin
                        state_d = FINISH;
                    end else begin
                        // Prefetch the next word in the same cycle so a held
                        // ready sees one beat per clock with no bubble.
                        src_read_en   = 1'b1;
                        src_read_addr = cnt_q + 1'b1;
                        cnt_d         = cnt_q + 1'b1;
                    end
                end
            end
            FINISH: begin
                busy       = 1'b1;
                done       = 1'b1;
                data_ready = 1'b1;
                cnt_d      = '0;
                state_d    = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_chip_stream_loader.sv
// Self-checking bench for chip_stream_loader on a small 4+2 word image.
// A per-cycle reference model predicts valid/busy/done/read timing and the
// expected beat stream from the address/sel rules; a table of stream runs
// plus hand-written reset and stall sequences drive it.
module tb_chip_stream_loader;

    localparam int IW    = 4;
    localparam int KW    = 2;
    localparam int TOTAL = IW + KW;
    localparam int AW    = 3;

    logic          clk = 1'b0;
    logic          arst_in;
    logic          start;
    logic          busy, done, src_read_en;
    logic [AW-1:0] src_read_addr;
    logic [15:0]   src_qout;
    logic [15:0]   a_input, b_input;
    logic          a_valid, a_ready, b_valid, b_ready;
    logic          int_mem_we, data_ready;

    always #5 clk = ~clk;

    chip_stream_loader #(
        .IO_DATA_WIDTH (16),
        .INPUT_WORDS   (IW),
        .KERNEL_WORDS  (KW),
        .SRC_ADDR_WIDTH(AW)
    ) dut (
        .clk          (clk),
        .arst_in      (arst_in),
        .start        (start),
        .busy         (busy),
        .done         (done),
        .src_read_en  (src_read_en),
        .src_read_addr(src_read_addr),
        .src_qout     (src_qout),
        .a_input      (a_input),
        .a_valid      (a_valid),
        .a_ready      (a_ready),
        .b_input      (b_input),
        .b_valid      (b_valid),
        .b_ready      (b_ready),
        .int_mem_we   (int_mem_we),
        .data_ready   (data_ready)
    );

    // Source memory: 1-cycle read latency, output held while read_en is low.
    logic [15:0] mem [0:7];
    always @(posedge clk) begin
        if (src_read_en) src_qout <= mem[src_read_addr];
    end

    typedef struct {
        int mode;        // 0 both ready, 1 b_ready toggles, 2 random readies
        int restart_at;  // extra start pulse when this many beats fired, -1 none
        int exp_fires;
        int exp_dones;
    } run_t;

    run_t runs[6];

    int          total_chk = 0;
    int          bad_chk   = 0;
    int          cyc       = 0;
    bit          m_active  = 0;
    int          start_cyc = 0;
    int          fire_idx  = 0;
    int          last_fire_cyc = -10;
    int          dut_fires = 0;
    int          dut_dones = 0;
    bit          prev_stall = 0;
    logic [15:0] prev_a, prev_b;
    logic [15:0] exp_a [TOTAL];
    logic [15:0] exp_b [TOTAL];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_chk++;
        if (act !== exp) begin
            bad_chk++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // One clock cycle: drive inputs after the falling edge, then compare all
    // outputs against the model before the next rising edge.
    task automatic tick(input logic st, input logic ar, input logic br);
        bit exp_valid, exp_done, exp_rd, fire, was_active;
        @(negedge clk);
        start   = st;
        a_ready = ar;
        b_ready = br;
        #1;
        exp_valid = m_active && (cyc >= start_cyc + 2) && (fire_idx < TOTAL);
        exp_done  = m_active && (fire_idx == TOTAL) && (cyc == last_fire_cyc + 1);
        fire      = exp_valid && ar && br;
        exp_rd    = (m_active && cyc == start_cyc + 1) || (fire && fire_idx < TOTAL - 1);
        check("a_valid", 32'(a_valid), 32'(exp_valid));
        check("b_valid", 32'(b_valid), 32'(exp_valid));
        check("int_mem_we", 32'(int_mem_we), 32'(fire));
        check("busy", 32'(busy), 32'(m_active && cyc > start_cyc));
        check("done", 32'(done), 32'(exp_done));
        check("data_ready", 32'(data_ready), 32'(exp_done));
        check("src_read_en", 32'(src_read_en), 32'(exp_rd));
        if (exp_valid && prev_stall) begin
            check("a_stable", 32'(a_input), 32'(prev_a));
            check("b_stable", 32'(b_input), 32'(prev_b));
        end
        if (fire) begin
            check("a_input", 32'(a_input), 32'(exp_a[fire_idx]));
            check("b_input", 32'(b_input), 32'(exp_b[fire_idx]));
            fire_idx++;
            if (fire_idx == TOTAL) last_fire_cyc = cyc;
        end
        if (int_mem_we) dut_fires++;
        if (done) dut_dones++;
        prev_stall = exp_valid && !fire;
        prev_a     = a_input;
        prev_b     = b_input;
        was_active = m_active;
        if (exp_done) m_active = 0;
        if (st && !was_active) begin
            m_active      = 1;
            start_cyc     = cyc;
            fire_idx      = 0;
            last_fire_cyc = -10;
            prev_stall    = 0;
        end
        cyc++;
    endtask

    task automatic run_stream(input int mode, input int restart_at);
        int   budget;
        bit   restarted;
        logic st, ar, br;
        dut_fires = 0;
        dut_dones = 0;
        budget    = 0;
        restarted = 0;
        tick(1'b1, 1'b1, 1'b1);
        while (m_active && budget < 200) begin
            st = 1'b0;
            if (!restarted && restart_at >= 0 && fire_idx == restart_at) begin
                st        = 1'b1;
                restarted = 1;
            end
            case (mode)
                0:       begin ar = 1'b1; br = 1'b1; end
                1:       begin ar = 1'b1; br = ((cyc % 2) == 1); end
                default: begin ar = 1'($urandom_range(0, 1)); br = 1'($urandom_range(0, 1)); end
            endcase
            tick(st, ar, br);
            budget++;
        end
        if (m_active) check("stream_timeout", 32'd1, 32'd0);
        repeat (4) tick(1'b0, 1'b1, 1'b1);
    endtask

    initial begin
        int budget;
        src_qout = '0;
        for (int i = 0; i < 8; i++) mem[i] = 16'(16'h0100 + i);
        // Expected beat stream straight from the address rules.
        for (int i = 0; i < TOTAL; i++) begin
            exp_a[i] = (i < IW) ? 16'(i) : 16'(16'h8000 + (i - IW));
            exp_b[i] = 16'(16'h0100 + i);
        end
        runs[0] = '{mode: 0, restart_at: -1, exp_fires: 6, exp_dones: 1};
        runs[1] = '{mode: 1, restart_at: -1, exp_fires: 6, exp_dones: 1};
        runs[2] = '{mode: 0, restart_at:  2, exp_fires: 6, exp_dones: 1};
        runs[3] = '{mode: 0, restart_at:  6, exp_fires: 6, exp_dones: 1};
        runs[4] = '{mode: 2, restart_at: -1, exp_fires: 6, exp_dones: 1};
        runs[5] = '{mode: 2, restart_at:  4, exp_fires: 6, exp_dones: 1};

        // Reset state.
        arst_in = 1'b1;
        start   = 1'b0;
        a_ready = 1'b0;
        b_ready = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check("rst_a_valid", 32'(a_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_a_input", 32'(a_input), 32'd0);
        check("rst_src_read_en", 32'(src_read_en), 32'd0);
        arst_in = 1'b0;

        // Idle with no start: everything stays low.
        repeat (20) begin
            tick(1'b0, 1'b0, 1'b0);
            check("idle_a_input", 32'(a_input), 32'd0);
            check("idle_b_input", 32'(b_input), 32'd0);
        end

        // Table-driven stream runs.
        for (int r = 0; r < 6; r++) begin
            run_stream(runs[r].mode, runs[r].restart_at);
            check($sformatf("run%0d_fires", r), 32'(dut_fires), 32'(runs[r].exp_fires));
            check($sformatf("run%0d_dones", r), 32'(dut_dones), 32'(runs[r].exp_dones));
        end

        // Extra random-ready streams.
        for (int r = 0; r < 4; r++) begin
            run_stream(2, -1);
            check("rand_fires", 32'(dut_fires), 32'd6);
            check("rand_dones", 32'(dut_dones), 32'd1);
        end

        // Reset in the middle of a stream, then a clean restart from word 0.
        tick(1'b1, 1'b1, 1'b1);
        budget = 0;
        while (fire_idx < 3 && budget < 50) begin
            tick(1'b0, 1'b1, 1'b1);
            budget++;
        end
        check("pre_reset_beats", 32'(fire_idx), 32'd3);
        @(negedge clk);
        arst_in = 1'b1;
        #1;
        check("arst_a_valid", 32'(a_valid), 32'd0);
        check("arst_b_valid", 32'(b_valid), 32'd0);
        check("arst_busy", 32'(busy), 32'd0);
        check("arst_src_read_en", 32'(src_read_en), 32'd0);
        m_active   = 0;
        prev_stall = 0;
        @(negedge clk);
        arst_in = 1'b0;
        run_stream(0, -1);
        check("post_reset_fires", 32'(dut_fires), 32'd6);
        check("post_reset_dones", 32'(dut_dones), 32'd1);

        // Only a_ready high: no beat may be written, address holds beat 0.
        dut_fires = 0;
        tick(1'b1, 1'b0, 1'b0);
        repeat (10) begin
            tick(1'b0, 1'b1, 1'b0);
            if (a_valid) check("a_only_addr", 32'(a_input), 32'h0000);
        end
        check("a_only_fires", 32'(dut_fires), 32'd0);
        budget = 0;
        while (m_active && budget < 50) begin
            tick(1'b0, 1'b1, 1'b1);
            budget++;
        end
        if (m_active) check("a_only_timeout", 32'd1, 32'd0);
        check("a_only_total_fires", 32'(dut_fires), 32'd6);

        $display("test done: total=%0d bad=%0d", total_chk, bad_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish, got timeout expected completion");
        $fatal(1);
    end

endmodule
